// File: rtl/pipeline_controller_pkg.sv
// Shared types and constants for the pipeline hazard/trap controller.
// Holds the FSM state enum, register-ID bundle and trap cause codes.
package pipeline_controller_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_TRAP  = 2'd2,
        ST_HALT  = 2'd3
    } ctrl_state_t;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } RegisterIDs_t;

    localparam logic [3:0] TRAPCAUSE_ILLEGAL    = 4'd2;
    localparam logic [3:0] TRAPCAUSE_BREAKPOINT = 4'd3;
    localparam logic [3:0] TRAPCAUSE_ECALL      = 4'd11;

    // Illegal wins over EBREAK, which wins over ECALL.
    function automatic logic [3:0] trap_cause(input logic illegal,
                                              input logic ebreak,
                                              input logic ecall);
        logic [3:0] cause;
        cause = 4'd0;
        if (illegal)
            cause = TRAPCAUSE_ILLEGAL;
        else if (ebreak)
            cause = TRAPCAUSE_BREAKPOINT;
        else if (ecall)
            cause = TRAPCAUSE_ECALL;
        return cause;
    endfunction

endpackage

// File: rtl/pipeline_controller_if.sv
// Bundle of ID/EX/MEM status inputs and stall/flush/redirect/trap outputs.
// The controller takes the slave modport; the pipeline side takes master.
interface pipeline_controller_if;
    import pipeline_controller_pkg::*;

    logic         i_ID_Valid;
    logic [31:0]  i_ID_PC;
    RegisterIDs_t i_ID_RegisterIDs;
    logic         i_ID_UsesRs1;
    logic         i_ID_UsesRs2;
    logic         i_ID_EnvCall;
    logic         i_ID_EnvBreak;
    logic         i_ID_IllegalInstruction;
    logic         i_EX_MemRead;
    logic [4:0]   i_EX_rd;
    logic         i_EX_Redirect;
    logic [31:0]  i_EX_Target;
    logic         i_MEM_Stall;
    logic         i_Resume;

    logic         o_Freeze;
    logic         o_IF_Stall;
    logic         o_ID_Stall;
    logic         o_ID_Flush;
    logic         o_EX_Bubble;
    logic         o_PC_Redirect;
    logic [31:0]  o_PC_Target;
    logic         o_TrapValid;
    logic [3:0]   o_TrapCause;
    logic [31:0]  o_TrapPC;
    logic         o_Halted;

    modport master (
        output i_ID_Valid, i_ID_PC, i_ID_RegisterIDs, i_ID_UsesRs1, i_ID_UsesRs2,
               i_ID_EnvCall, i_ID_EnvBreak, i_ID_IllegalInstruction,
               i_EX_MemRead, i_EX_rd, i_EX_Redirect, i_EX_Target,
               i_MEM_Stall, i_Resume,
        input  o_Freeze, o_IF_Stall, o_ID_Stall, o_ID_Flush, o_EX_Bubble,
               o_PC_Redirect, o_PC_Target, o_TrapValid, o_TrapCause,
               o_TrapPC, o_Halted
    );

    modport slave (
        input  i_ID_Valid, i_ID_PC, i_ID_RegisterIDs, i_ID_UsesRs1, i_ID_UsesRs2,
               i_ID_EnvCall, i_ID_EnvBreak, i_ID_IllegalInstruction,
               i_EX_MemRead, i_EX_rd, i_EX_Redirect, i_EX_Target,
               i_MEM_Stall, i_Resume,
        output o_Freeze, o_IF_Stall, o_ID_Stall, o_ID_Flush, o_EX_Bubble,
               o_PC_Redirect, o_PC_Target, o_TrapValid, o_TrapCause,
               o_TrapPC, o_Halted
    );

endinterface

// File: rtl/pipeline_controller_hazard_detect.sv
// Combinational load-use comparator: flags an ID source register that
// matches the destination of a load currently in EX.
module hazard_detect (
    input  logic       i_ID_Valid,
    input  logic [4:0] i_ID_Rs1,
    input  logic [4:0] i_ID_Rs2,
    input  logic       i_ID_UsesRs1,
    input  logic       i_ID_UsesRs2,
    input  logic       i_EX_MemRead,
    input  logic [4:0] i_EX_rd,
    output logic       o_LoadUse
);

    logic [1:0] w_match;
    logic [4:0] w_src [2];
    logic [1:0] w_uses;

    assign w_src[0] = i_ID_Rs1;
    assign w_src[1] = i_ID_Rs2;
    assign w_uses   = {i_ID_UsesRs2, i_ID_UsesRs1};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign w_match[gi] = w_uses[gi] && (w_src[gi] == i_EX_rd);
        end
    endgenerate

    // x0 is hardwired zero, so a load "to x0" never creates a dependency.
    assign o_LoadUse = i_ID_Valid && i_EX_MemRead && (i_EX_rd != 5'd0) && (|w_match);

endmodule

// File: rtl/pipeline_controller.sv
// Hazard and trap sequencer: drives stall/flush/bubble/redirect for the
// five-stage core and walks RUN -> DRAIN -> TRAP (-> HALT) on ID traps.
module pipeline_controller
    import pipeline_controller_pkg::*;
#(
    parameter logic [31:0] TRAP_VECTOR    = 32'h0000_0100,
    parameter int          DRAIN_CYCLES   = 3,
    parameter bit          HALT_ON_EBREAK = 1'b1
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset_n,
    pipeline_controller_if.slave bus
);

    localparam int              CNT_W    = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    ctrl_state_t      r_state;
    ctrl_state_t      w_state_next;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic [31:0]      r_trap_pc;
    logic [3:0]       r_trap_cause;

    logic        w_load_use;
    logic        w_trap_req;
    logic        w_latch_trap;
    logic        w_freeze;
    logic        w_stall;
    logic        w_flush;
    logic        w_bubble;
    logic        w_redirect;
    logic [31:0] w_target;
    logic        w_trap_valid;
    logic        w_halted;
    logic        w_unused_rd;

    assign w_unused_rd = ^bus.i_ID_RegisterIDs.rd;

    hazard_detect u_hazard_detect (
        .i_ID_Valid   (bus.i_ID_Valid),
        .i_ID_Rs1     (bus.i_ID_RegisterIDs.rs1),
        .i_ID_Rs2     (bus.i_ID_RegisterIDs.rs2),
        .i_ID_UsesRs1 (bus.i_ID_UsesRs1),
        .i_ID_UsesRs2 (bus.i_ID_UsesRs2),
        .i_EX_MemRead (bus.i_EX_MemRead),
        .i_EX_rd      (bus.i_EX_rd),
        .o_LoadUse    (w_load_use)
    );

    assign w_trap_req = bus.i_ID_Valid &&
                        (bus.i_ID_EnvCall || bus.i_ID_EnvBreak || bus.i_ID_IllegalInstruction);

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_latch_trap = 1'b0;
        w_freeze     = 1'b0;
        w_stall      = 1'b0;
        w_flush      = 1'b0;
        w_bubble     = 1'b0;
        w_redirect   = 1'b0;
        w_target     = 32'd0;
        w_trap_valid = 1'b0;
        w_halted     = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (bus.i_MEM_Stall) begin
                    w_freeze = 1'b1;
                end else if (bus.i_EX_Redirect) begin
                    // ID is on the wrong path, so its trap flags and hazards are moot.
                    w_redirect = 1'b1;
                    w_target   = bus.i_EX_Target;
                    w_flush    = 1'b1;
                    w_bubble   = 1'b1;
                end else if (w_trap_req) begin
                    w_latch_trap = 1'b1;
                    w_count_next = CNT_LOAD;
                    w_stall      = 1'b1;
                    w_bubble     = 1'b1;
                    w_state_next = ST_DRAIN;
                end else if (w_load_use) begin
                    w_stall  = 1'b1;
                    w_bubble = 1'b1;
                end
            end

            ST_DRAIN: begin
                w_stall  = 1'b1;
                w_bubble = 1'b1;
                if (bus.i_MEM_Stall) begin
                    w_freeze = 1'b1;
                end else begin
                    w_count_next = r_count - CNT_ONE;
                    if (r_count <= CNT_ONE)
                        w_state_next = ST_TRAP;
                end
            end

            ST_TRAP: begin
                w_flush  = 1'b1;
                w_bubble = 1'b1;
                if (HALT_ON_EBREAK && (r_trap_cause == TRAPCAUSE_BREAKPOINT)) begin
                    w_state_next = ST_HALT;
                end else begin
                    w_trap_valid = 1'b1;
                    w_redirect   = 1'b1;
                    w_target     = TRAP_VECTOR;
                    w_state_next = ST_RUN;
                end
            end

            ST_HALT: begin
                w_halted = 1'b1;
                w_stall  = 1'b1;
                w_bubble = 1'b1;
                if (bus.i_Resume) begin
                    w_redirect   = 1'b1;
                    w_target     = r_trap_pc + 32'd4;
                    w_flush      = 1'b1;
                    w_state_next = ST_RUN;
                end
            end

            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_state      <= ST_RUN;
            r_count      <= '0;
            r_trap_pc    <= 32'd0;
            r_trap_cause <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            if (w_latch_trap) begin
                r_trap_pc    <= bus.i_ID_PC;
                r_trap_cause <= trap_cause(bus.i_ID_IllegalInstruction,
                                           bus.i_ID_EnvBreak,
                                           bus.i_ID_EnvCall);
            end
        end
    end

    // Combinational outputs are gated by reset so the pipe sees all zeros during it.
    assign bus.o_Freeze      = w_freeze     & i_Reset_n;
    assign bus.o_IF_Stall    = w_stall      & i_Reset_n;
    assign bus.o_ID_Stall    = w_stall      & i_Reset_n;
    assign bus.o_ID_Flush    = w_flush      & i_Reset_n;
    assign bus.o_EX_Bubble   = w_bubble     & i_Reset_n;
    assign bus.o_PC_Redirect = w_redirect   & i_Reset_n;
    assign bus.o_PC_Target   = w_target     & {32{i_Reset_n}};
    assign bus.o_TrapValid   = w_trap_valid & i_Reset_n;
    assign bus.o_Halted      = w_halted     & i_Reset_n;
    assign bus.o_TrapPC      = r_trap_pc;
    assign bus.o_TrapCause   = r_trap_cause;

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller: expected output vectors are queued
// per cycle and compared against the DUT mid-cycle.
module tb_pipeline_controller;
    import pipeline_controller_pkg::*;

    typedef struct packed {
        logic        freeze;
        logic        if_stall;
        logic        id_stall;
        logic        id_flush;
        logic        ex_bubble;
        logic        pc_redirect;
        logic [31:0] pc_target;
        logic        trap_valid;
        logic [3:0]  trap_cause;
        logic [31:0] trap_pc;
        logic        halted;
    } exp_t;

    typedef struct {
        string tag;
        exp_t  v;
    } sb_entry_t;

    logic clk;
    logic rst_n;
    pipeline_controller_if bus ();

    pipeline_controller #(
        .TRAP_VECTOR    (32'h0000_0100),
        .DRAIN_CYCLES   (3),
        .HALT_ON_EBREAK (1'b1)
    ) dut (
        .i_Clock   (clk),
        .i_Reset_n (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sb_entry_t   sb_q[$];
    int          total;
    int          bad;
    exp_t        e;
    logic [3:0]  exp_cause;
    logic [31:0] exp_tpc;

    function automatic exp_t base();
        exp_t b;
        b            = '0;
        b.trap_cause = exp_cause;
        b.trap_pc    = exp_tpc;
        return b;
    endfunction

    function automatic exp_t stall_bubble(input exp_t b);
        exp_t r;
        r           = b;
        r.if_stall  = 1'b1;
        r.id_stall  = 1'b1;
        r.ex_bubble = 1'b1;
        return r;
    endfunction

    task automatic idle();
        bus.i_ID_Valid              = 1'b0;
        bus.i_ID_PC                 = 32'd0;
        bus.i_ID_RegisterIDs        = '0;
        bus.i_ID_UsesRs1            = 1'b0;
        bus.i_ID_UsesRs2            = 1'b0;
        bus.i_ID_EnvCall            = 1'b0;
        bus.i_ID_EnvBreak           = 1'b0;
        bus.i_ID_IllegalInstruction = 1'b0;
        bus.i_EX_MemRead            = 1'b0;
        bus.i_EX_rd                 = 5'd0;
        bus.i_EX_Redirect           = 1'b0;
        bus.i_EX_Target             = 32'd0;
        bus.i_MEM_Stall             = 1'b0;
        bus.i_Resume                = 1'b0;
    endtask

    task automatic nxt();
        @(negedge clk);
        idle();
    endtask

    // Queue the expectation for the cycle just driven, then check it mid-cycle.
    task automatic chk(input string tag);
        sb_entry_t ent;
        exp_t      obs;
        sb_q.push_back('{tag: tag, v: e});
        #2;
        obs.freeze      = bus.o_Freeze;
        obs.if_stall    = bus.o_IF_Stall;
        obs.id_stall    = bus.o_ID_Stall;
        obs.id_flush    = bus.o_ID_Flush;
        obs.ex_bubble   = bus.o_EX_Bubble;
        obs.pc_redirect = bus.o_PC_Redirect;
        obs.pc_target   = bus.o_PC_Target;
        obs.trap_valid  = bus.o_TrapValid;
        obs.trap_cause  = bus.o_TrapCause;
        obs.trap_pc     = bus.o_TrapPC;
        obs.halted      = bus.o_Halted;
        ent = sb_q.pop_front();
        total++;
        assert (obs === ent.v)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", ent.tag, obs, ent.v);
        end
        $display("check %s obs=%h exp=%h", ent.tag, obs, ent.v);
    endtask

    // Trap entry + drain common to every trapping test; ID must be driven by caller.
    task automatic drain3(input string pfx);
        for (int i = 0; i < 3; i++) begin
            nxt();
            if (i == 0) begin
                bus.i_EX_Redirect = 1'b1;
                bus.i_EX_Target   = 32'h0000_3000;
            end
            e = stall_bubble(base());
            chk({pfx, "_drain"});
        end
    endtask

    task automatic run_ebreak(input logic [31:0] pc, input string pfx, input int halt_cycles,
                              input logic [31:0] resume_target);
        nxt();
        bus.i_ID_Valid    = 1'b1;
        bus.i_ID_PC       = pc;
        bus.i_ID_EnvBreak = 1'b1;
        bus.i_ID_EnvCall  = 1'b1;
        e = stall_bubble(base());
        chk({pfx, "_detect"});
        exp_cause = 4'd3;
        exp_tpc   = pc;
        drain3(pfx);
        nxt();
        e = base();
        e.id_flush  = 1'b1;
        e.ex_bubble = 1'b1;
        chk({pfx, "_trap_nohalt_vector"});
        for (int i = 0; i < halt_cycles; i++) begin
            nxt();
            e = stall_bubble(base());
            e.halted = 1'b1;
            chk({pfx, "_halted"});
        end
        nxt();
        bus.i_Resume = 1'b1;
        e = stall_bubble(base());
        e.halted      = 1'b1;
        e.pc_redirect = 1'b1;
        e.pc_target   = resume_target;
        e.id_flush    = 1'b1;
        chk({pfx, "_resume"});
        nxt();
        e = base();
        chk({pfx, "_back_run"});
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        exp_cause = 4'd0;
        exp_tpc   = 32'd0;

        // Reset with aggressive inputs: every output must be zero.
        rst_n = 1'b0;
        idle();
        bus.i_EX_Redirect = 1'b1;
        bus.i_EX_Target   = 32'h0000_2000;
        bus.i_ID_Valid    = 1'b1;
        bus.i_ID_EnvCall  = 1'b1;
        e = base();
        chk("reset");

        nxt();
        rst_n = 1'b1;
        e = base();
        chk("idle");

        // Load-use on rs1, then re-evaluation with the load gone from EX.
        nxt();
        bus.i_ID_Valid = 1'b1; bus.i_ID_RegisterIDs = '{rs1: 5'd5, rs2: 5'd1, rd: 5'd2};
        bus.i_ID_UsesRs1 = 1'b1; bus.i_EX_MemRead = 1'b1; bus.i_EX_rd = 5'd5;
        e = stall_bubble(base());
        chk("loaduse_rs1");
        nxt();
        bus.i_ID_Valid = 1'b1; bus.i_ID_RegisterIDs = '{rs1: 5'd5, rs2: 5'd1, rd: 5'd2};
        bus.i_ID_UsesRs1 = 1'b1; bus.i_EX_rd = 5'd5;
        e = base();
        chk("loaduse_one_cycle");

        nxt();
        bus.i_ID_Valid = 1'b1; bus.i_ID_RegisterIDs = '{rs1: 5'd0, rs2: 5'd3, rd: 5'd2};
        bus.i_ID_UsesRs1 = 1'b1; bus.i_EX_MemRead = 1'b1; bus.i_EX_rd = 5'd0;
        e = base();
        chk("loaduse_rd0");

        nxt();
        bus.i_ID_Valid = 1'b1; bus.i_ID_RegisterIDs = '{rs1: 5'd4, rs2: 5'd9, rd: 5'd2};
        bus.i_ID_UsesRs1 = 1'b1; bus.i_EX_MemRead = 1'b1; bus.i_EX_rd = 5'd9;
        e = base();
        chk("loaduse_rs2_unused");
        nxt();
        bus.i_ID_Valid = 1'b1; bus.i_ID_RegisterIDs = '{rs1: 5'd4, rs2: 5'd9, rd: 5'd2};
        bus.i_ID_UsesRs2 = 1'b1; bus.i_EX_MemRead = 1'b1; bus.i_EX_rd = 5'd9;
        e = stall_bubble(base());
        chk("loaduse_rs2");

        // Branch redirect overrides an ECALL in ID and a load-use hazard.
        nxt();
        bus.i_EX_Redirect = 1'b1; bus.i_EX_Target = 32'h0000_2000;
        bus.i_ID_Valid = 1'b1; bus.i_ID_PC = 32'h30; bus.i_ID_EnvCall = 1'b1;
        bus.i_ID_RegisterIDs = '{rs1: 5'd6, rs2: 5'd0, rd: 5'd1};
        bus.i_ID_UsesRs1 = 1'b1; bus.i_EX_MemRead = 1'b1; bus.i_EX_rd = 5'd6;
        e = base();
        e.pc_redirect = 1'b1; e.pc_target = 32'h0000_2000;
        e.id_flush = 1'b1; e.ex_bubble = 1'b1;
        chk("redirect_over_ecall");
        nxt();
        e = base();
        chk("redirect_stays_run");

        nxt();
        bus.i_MEM_Stall = 1'b1; bus.i_EX_Redirect = 1'b1; bus.i_EX_Target = 32'h44;
        e = base();
        e.freeze = 1'b1;
        chk("freeze_over_redirect");

        nxt();
        bus.i_ID_Valid = 1'b0; bus.i_ID_EnvCall = 1'b1; bus.i_ID_PC = 32'h38;
        e = base();
        chk("ecall_invalid_id");

        // ECALL at 0x40: TrapValid at T+4.
        nxt();
        bus.i_ID_Valid = 1'b1; bus.i_ID_PC = 32'h40; bus.i_ID_EnvCall = 1'b1;
        e = stall_bubble(base());
        chk("ecall_detect");
        exp_cause = 4'd11;
        exp_tpc   = 32'h40;
        drain3("ecall");
        nxt();
        e = base();
        e.trap_valid = 1'b1; e.pc_redirect = 1'b1; e.pc_target = 32'h100;
        e.id_flush = 1'b1; e.ex_bubble = 1'b1;
        chk("ecall_trap");
        nxt();
        e = base();
        chk("ecall_back_run");

        // ECALL with load-use, two freeze cycles inside DRAIN: TrapValid at T+6.
        nxt();
        bus.i_ID_Valid = 1'b1; bus.i_ID_PC = 32'h50; bus.i_ID_EnvCall = 1'b1;
        bus.i_ID_RegisterIDs = '{rs1: 5'd7, rs2: 5'd0, rd: 5'd1};
        bus.i_ID_UsesRs1 = 1'b1; bus.i_EX_MemRead = 1'b1; bus.i_EX_rd = 5'd7;
        e = stall_bubble(base());
        chk("frz_detect");
        exp_tpc = 32'h50;
        for (int i = 0; i < 2; i++) begin
            nxt();
            bus.i_MEM_Stall = 1'b1;
            e = stall_bubble(base());
            e.freeze = 1'b1;
            chk("frz_freeze");
        end
        drain3("frz");
        nxt();
        e = base();
        e.trap_valid = 1'b1; e.pc_redirect = 1'b1; e.pc_target = 32'h100;
        e.id_flush = 1'b1; e.ex_bubble = 1'b1;
        chk("frz_trap");

        // Illegal (with ECALL also set) then reset mid-drain.
        nxt();
        bus.i_ID_Valid = 1'b1; bus.i_ID_PC = 32'h60;
        bus.i_ID_IllegalInstruction = 1'b1; bus.i_ID_EnvCall = 1'b1;
        e = stall_bubble(base());
        chk("ill_detect");
        exp_cause = 4'd2;
        exp_tpc   = 32'h60;
        nxt();
        e = stall_bubble(base());
        chk("ill_drain");
        nxt();
        rst_n = 1'b0;
        bus.i_MEM_Stall = 1'b1; bus.i_Resume = 1'b1;
        exp_cause = 4'd0;
        exp_tpc   = 32'd0;
        e = base();
        chk("ill_reset_mid_drain");
        nxt();
        rst_n = 1'b1;
        e = base();
        chk("ill_after_reset");
        for (int i = 0; i < 5; i++) begin
            nxt();
            e = base();
            chk("ill_no_trap_pulse");
        end

        // EBREAK (over ECALL) halts; resume to PC+4, including 32-bit wrap.
        run_ebreak(32'h80, "ebrk", 2, 32'h84);
        run_ebreak(32'hFFFF_FFFC, "ebrk_wrap", 0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_controller.md
# pipeline_controller

Central hazard and trap sequencer for the five-stage core. It consumes the decode unit's classification of the instruction in ID, plus the EX/MEM status, and drives every stall, flush, bubble and PC-redirect signal. It also runs the trap state machine for ECALL, EBREAK and illegal instructions. It sits beside the pipeline registers and owns no datapath state except the latched trap PC and cause.

## Interface

Parameters:
- TRAP_VECTOR, 32'h0000_0100: PC loaded on trap entry.
- DRAIN_CYCLES, 3: unfrozen cycles needed for instructions older than the trapping one to retire through EX/MEM/WB. Must be at least 1.
- HALT_ON_EBREAK, 1: when 1, EBREAK parks the core in HALT instead of vectoring.

Ports:
- i_Clock  in  1  core clock. Single clock; reset is asynchronous and active-low.
- i_Reset_n  in  1  asynchronous, active-low reset.
- i_ID_Valid  in  1  ID holds a real instruction.
- i_ID_PC  in  32  PC of the ID instruction.
- i_ID_RegisterIDs  in  RegisterIDs_t  rs1/rs2/rd of the ID instruction.
- i_ID_UsesRs1, i_ID_UsesRs2  in  1 each  ID instruction reads rs1/rs2.
- i_ID_EnvCall, i_ID_EnvBreak, i_ID_IllegalInstruction  in  1 each  decode unit trap flags.
- i_EX_MemRead  in  1  EX holds a load.
- i_EX_rd  in  5  destination register of the EX instruction.
- i_EX_Redirect  in  1  branch or jump resolved taken in EX.
- i_EX_Target  in  32  resolved target.
- i_MEM_Stall  in  1  data cache busy; the whole pipe must freeze.
- i_Resume  in  1  debug resume from HALT.
- o_Freeze  out  1  hold all pipeline registers.
- o_IF_Stall, o_ID_Stall  out  1 each  hold PC and the IF/ID register.
- o_ID_Flush  out  1  clear the IF/ID register.
- o_EX_Bubble  out  1  load a NOP into ID/EX.
- o_PC_Redirect  out  1  load o_PC_Target into PC.
- o_PC_Target  out  32  redirect target.
- o_TrapValid  out  1  one-cycle trap commit pulse.
- o_TrapCause  out  4  latched cause.
- o_TrapPC  out  32  latched PC of the trapping instruction.
- o_Halted  out  1  core is in HALT.

## Operation

States: RUN, DRAIN, TRAP, HALT.

RUN applies the following per-cycle priorities, highest first:
1. **i_MEM_Stall:** o_Freeze=1. No other output is asserted and no state changes.
2. **i_EX_Redirect:** o_PC_Redirect=1, o_PC_Target=i_EX_Target, o_ID_Flush=1, o_EX_Bubble=1. Any trap flag or hazard in ID is ignored because ID is on the wrong path.
3. **Trap in ID:** i_ID_Valid and any trap flag is set.
   - Latch o_TrapPC=i_ID_PC.
   - Latch cause with priority illegal=2 > EBREAK=3 > ECALL=11.
   - Load the counter with DRAIN_CYCLES.
   - Assert o_IF_Stall, o_ID_Stall and o_EX_Bubble; move to DRAIN.
4. **Load-use:** i_ID_Valid, i_EX_MemRead, i_EX_rd!=0, and rs1 or rs2 matches i_EX_rd with the corresponding Uses bit set. Assert o_IF_Stall, o_ID_Stall and o_EX_Bubble for this cycle only.

DRAIN:
- Assert o_IF_Stall, o_ID_Stall and o_EX_Bubble every cycle.
- i_MEM_Stall gives o_Freeze=1 and the counter holds.
- Otherwise the counter decrements; when it decrements from 1, move to TRAP.
- i_EX_Redirect is ignored, since EX holds only bubbles.

TRAP lasts one cycle:
- If the cause is EBREAK and HALT_ON_EBREAK=1: o_ID_Flush=1, o_EX_Bubble=1, move to HALT. No redirect and no TrapValid.
- Otherwise: o_TrapValid=1, o_PC_Redirect=1, o_PC_Target=TRAP_VECTOR, o_ID_Flush=1, o_EX_Bubble=1, move to RUN.

HALT:
- Assert o_Halted, o_IF_Stall, o_ID_Stall and o_EX_Bubble.
- On i_Resume, in the same cycle: o_PC_Redirect=1, o_PC_Target=o_TrapPC+4 (32-bit wrap), o_ID_Flush=1, move to RUN.

## Timing

- **Reset:**
  - While i_Reset_n is low, state is RUN, counter=0, o_TrapPC=0 and o_TrapCause=0.
  - All outputs are forced to 0 while i_Reset_n is low.
  - Reset mid-DRAIN or mid-HALT discards the pending trap.
- **Output timing:** stall, flush, bubble and redirect outputs are combinational from state and inputs, with zero latency. o_TrapPC and o_TrapCause are registered and update on the edge that leaves RUN for DRAIN.
- **Load-use:** costs exactly 1 cycle; the next cycle re-evaluates with the load in MEM.
- **Trap latency:** the trap is detected at cycle T, and with no freeze o_TrapValid is high at cycle T+DRAIN_CYCLES+1. Each freeze cycle adds one cycle.
- **Simultaneous events:** EX redirect together with a load-use hazard gives redirect only. An ID trap together with a load-use hazard takes the trap path; the counter covers the load.

## Structure

- Put the state enum and the TRAPCAUSE_ILLEGAL/BREAKPOINT/ECALL defines in a shared pipeline_control.svh, beside the existing decode_unit.svh.
- Use one sub-module, hazard_detect: a combinational load-use comparator that outputs a single w_LoadUse bit.
- Implementation is 1 FSM, 1 down-counter sized by $clog2(DRAIN_CYCLES+1), and the trap PC/cause registers.

## Test plan

- **Load-use:** EX load with rd=5, ID rs1=5 and UsesRs1=1 -> stall and bubble high for exactly 1 cycle. The same case with rd=0 -> no stall.
- **Branch redirect:** i_EX_Redirect with target 0x2000 while the ID instruction has EnvCall=1 -> redirect to 0x2000 and flush; state stays RUN; no trap latched.
- **ECALL:** ECALL at PC 0x40 with DRAIN_CYCLES=3 -> o_TrapValid at T+4, o_PC_Target=0x100, cause=11, o_TrapPC=0x40.
- **Freeze during drain:** ECALL with 2 cycles of i_MEM_Stall inside DRAIN -> o_Freeze high for those 2 cycles; o_TrapValid at T+6.
- **EBREAK halt:** EBREAK at 0x80 with HALT_ON_EBREAK=1 -> o_Halted stays high; i_Resume -> redirect to 0x84, then RUN.
- **Reset mid-drain:** illegal instruction, then reset asserted during DRAIN -> all outputs 0 and state RUN; no o_TrapValid pulse ever appears.
